// File: rtl/box_filter_pkg.sv
// Shared types for the streaming 3x3 smoothing filter.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
//
// Contents: filter mode encoding, frame FSM states, accumulator width helper.
package box_filter_pkg;

  typedef enum logic [1:0] {
    MODE_BOX    = 2'b00,
    MODE_BYPASS = 2'b01,
    MODE_GAUSS  = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    FILL,
    RUN,
    EOL,
    FLUSH
  } state_e;

  // Nine taps of PIX_W bits (or a 16-weight kernel) fit in four extra bits.
  function automatic int sum_width(input int pix_w);
    return pix_w + 4;
  endfunction

endpackage

// File: rtl/box_filter_stream_line_buffer.sv
// One raster row of pixel storage for the smoothing window.
// Latency: read is combinational; write lands on the next clk edge.
// Backpressure: none; the caller decides when to write.
//
// Ports: clk; i_we write enable; i_addr column; i_wdata new pixel;
//        o_rdata old pixel at i_addr (read-before-write on the same column).
module line_buffer
  import box_filter_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [PIX_W-1:0] i_wdata,
  output logic [PIX_W-1:0] o_rdata
);

  logic [PIX_W-1:0] r_mem [DEPTH];

  assign o_rdata = r_mem[i_addr];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

endmodule

// File: rtl/box_filter_stream.sv
// Streaming 3x3 smoothing filter (box mean / bypass / optional gaussian), edge-replicated borders.
// Latency: result registered 1 clk after the accepting input transfer.
// Backpressure: in_ready drops when the output register is full and stalled, and during EOL/FLUSH.
//
// Ports: clk, reset (sync, active-high); mode (sampled at pixel (0,0));
//        in_valid/in_ready/in_data input stream; out_valid/out_ready/out_data output stream;
//        out_sof marks output (0,0), out_eol marks the last column of each row.
// Build option: define GAUSS_EN to enable the 1-2-1 gaussian kernel on mode 2'b10.
module box_filter_stream
  import box_filter_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 128,
  parameter int IMG_H = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_data,
  output logic             out_sof,
  output logic             out_eol
);

  localparam int SUM_W = sum_width(PIX_W);
  localparam int AW    = $clog2(IMG_W);
  localparam int CW    = $clog2(IMG_W + 1);
  localparam int RW    = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_END  = CW'(IMG_W);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  state_e           r_state, w_state_nxt;
  logic [CW-1:0]    r_col;        // input column, or flush step 0..IMG_W
  logic [RW-1:0]    r_row;        // current input row
  logic [1:0]       r_mode;
  logic [PIX_W-1:0] r_win [3][3]; // [column left..right][row top..bottom]

  logic             r_out_valid, r_out_sof, r_out_eol;
  logic [PIX_W-1:0] r_out_data;

  logic             w_slot, w_fill_out, w_acc, w_step, w_emit, w_row_end;
  logic [PIX_W-1:0] w_lb0_rd, w_lb1_rd, w_res;
  logic [PIX_W-1:0] w_col [3];
  logic [PIX_W-1:0] w_win [3][3];
  logic [SUM_W-1:0] w_sum;
`ifdef GAUSS_EN
  logic [SUM_W-1:0] w_gsum;
`endif

  // lb0 holds the previous input row, lb1 the one before it.
  line_buffer #(.PIX_W(PIX_W), .DEPTH(IMG_W), .AW(AW)) u_lb0 (
    .clk(clk), .i_we(w_acc), .i_addr(r_col[AW-1:0]), .i_wdata(in_data), .o_rdata(w_lb0_rd)
  );
  line_buffer #(.PIX_W(PIX_W), .DEPTH(IMG_W), .AW(AW)) u_lb1 (
    .clk(clk), .i_we(w_acc), .i_addr(r_col[AW-1:0]), .i_wdata(w_lb0_rd), .o_rdata(w_lb1_rd)
  );

  assign w_slot     = out_ready | ~r_out_valid;
  assign w_fill_out = (r_row == RW'(1)) && (r_col == CW'(1));

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    w_step      = 1'b0;
    w_emit      = 1'b0;
    w_row_end   = 1'b0;
    case (r_state)
      // Only pixel (1,1) of FILL creates a result, so only it needs a free output slot.
      FILL: in_ready = ~w_fill_out | w_slot;
      RUN:  in_ready = w_slot;
      EOL: begin
        if (w_slot) begin
          w_emit      = 1'b1;
          w_row_end   = 1'b1;
          w_state_nxt = (r_row == ROW_LAST) ? FLUSH : RUN;
        end
      end
      FLUSH: begin
        // Step 0 only primes the window; steps 1..IMG_W-1 emit; step IMG_W emits the last column.
        if (w_slot) begin
          if (r_col == COL_END) begin
            w_emit      = 1'b1;
            w_row_end   = 1'b1;
            w_state_nxt = FILL;
          end else begin
            w_step = 1'b1;
            w_emit = (r_col != '0);
          end
        end
      end
      default: w_state_nxt = FILL;
    endcase
    if (reset) begin
      in_ready = 1'b0;
    end
    w_acc = in_valid & in_ready;
    if (w_acc) begin
      w_step = 1'b1;
      if (r_state == FILL) begin
        if (w_fill_out) begin
          w_emit      = 1'b1;
          w_state_nxt = RUN;
        end
      end else begin
        w_emit = (r_col != '0);
        if (r_col == COL_LAST) begin
          w_state_nxt = EOL;
        end
      end
    end
  end

  // New window column: top/mid from the line buffers, bottom from the stream.
  // Row 1 replicates row 0 upward; flush replicates the last row downward.
  always_comb begin
    w_col[1] = w_lb0_rd;
    if (r_state == FLUSH) begin
      w_col[0] = w_lb1_rd;
      w_col[2] = w_lb0_rd;
    end else begin
      w_col[0] = (r_row == RW'(1)) ? w_lb0_rd : w_lb1_rd;
      w_col[2] = in_data;
    end
  end

  // Window seen by the arithmetic: the shifted-in view, or the right edge replicated.
  always_comb begin
    w_win[0] = r_win[1];
    w_win[1] = r_win[2];
    w_win[2] = w_row_end ? r_win[2] : w_col;
  end

  always_comb begin
    w_sum = '0;
`ifdef GAUSS_EN
    w_gsum = '0;
`endif
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        w_sum = w_sum + SUM_W'(w_win[i][j]);
`ifdef GAUSS_EN
        w_gsum = w_gsum + (SUM_W'(w_win[i][j]) << ((i == 1 ? 1 : 0) + (j == 1 ? 1 : 0)));
`endif
      end
    end
    w_res = PIX_W'(w_sum / SUM_W'(9));
    if (r_mode == MODE_BYPASS) begin
      w_res = w_win[1][1];
    end
`ifdef GAUSS_EN
    else if (r_mode == MODE_GAUSS) begin
      w_res = PIX_W'(w_gsum >> 4);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FILL;
      r_col   <= '0;
      r_row   <= '0;
      r_mode  <= MODE_BOX;
    end else begin
      r_state <= w_state_nxt;
      if (w_acc && r_state == FILL && r_row == '0 && r_col == '0) begin
        r_mode <= mode;
      end
      if (w_step) begin
        if (r_state != FLUSH && r_col == COL_LAST) begin
          r_col <= '0;
          if (r_state == FILL) begin
            r_row <= r_row + 1'b1;
          end
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      if (r_state == EOL && w_emit && r_row != ROW_LAST) begin
        r_row <= r_row + 1'b1;
      end
      if (r_state == FLUSH && w_row_end) begin
        r_col <= '0;
        r_row <= '0;
      end
    end
  end

  // Column 0 fills the whole window so column -1 replicates column 0.
  always_ff @(posedge clk) begin
    if (w_step) begin
      if (r_col == '0) begin
        r_win[0] <= w_col;
        r_win[1] <= w_col;
        r_win[2] <= w_col;
      end else begin
        r_win[0] <= r_win[1];
        r_win[1] <= r_win[2];
        r_win[2] <= w_col;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sof   <= 1'b0;
      r_out_eol   <= 1'b0;
    end else if (w_emit) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_res;
      r_out_sof   <= (r_state == FILL);
      r_out_eol   <= w_row_end;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sof   = r_out_sof;
  assign out_eol   = r_out_eol;

endmodule

// File: tb/tb_box_filter_stream.sv
module tb_box_filter_stream;

  typedef struct packed {
    logic [7:0] dat;
    logic       sof;
    logic       eol;
  } exp_t;

  localparam int K_C100 = 0;
  localparam int K_RAMP = 1;
  localparam int K_C255 = 2;
  localparam int K_HASH = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [1:0][1:0] md;
  logic [1:0]      in_valid, in_ready, out_valid, out_sof, out_eol;
  logic [1:0][7:0] in_data, out_data;
  logic            rdy0, rdy1, stall_en;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   cap0[$];
  logic        hold_v [2];
  logic [10:0] hold_w [2];
  logic        mon_rdy;
  exp_t        mon_e;

  box_filter_stream #(.PIX_W(8), .IMG_W(4), .IMG_H(4)) u_dut0 (
    .clk(clk), .reset(reset), .mode(md[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(rdy0), .out_data(out_data[0]),
    .out_sof(out_sof[0]), .out_eol(out_eol[0])
  );

  box_filter_stream #(.PIX_W(8), .IMG_W(8), .IMG_H(5)) u_dut1 (
    .clk(clk), .reset(reset), .mode(md[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(rdy1), .out_data(out_data[1]),
    .out_sof(out_sof[1]), .out_eol(out_eol[1])
  );

  function automatic int img_w(input int d);
    return (d == 0) ? 4 : 8;
  endfunction

  function automatic int img_h(input int d);
    return (d == 0) ? 4 : 5;
  endfunction

  function automatic int pat(input int kind, input int w, input int r, input int c);
    case (kind)
      K_C100:  return 100;
      K_RAMP:  return r * w + c;
      K_C255:  return 255;
      default: return (r * 37 + c * 53) % 256;
    endcase
  endfunction

  function automatic int clampi(input int v, input int n);
    if (v < 0) return 0;
    if (v > n - 1) return n - 1;
    return v;
  endfunction

  // Reference filter straight from the definition: clamped 3x3 neighbourhood.
  function automatic int model(input int kind, input int w, input int h, input int m,
                               input int r, input int c);
    int s;
    int rr;
    int cc;
    s = 0;
    if (m == 1) return pat(kind, w, r, c);
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        rr = clampi(r + dr, h);
        cc = clampi(c + dc, w);
`ifdef GAUSS_EN
        if (m == 2) s += pat(kind, w, rr, cc) * (dr == 0 ? 2 : 1) * (dc == 0 ? 2 : 1);
        else
`endif
        s += pat(kind, w, rr, cc);
      end
    end
`ifdef GAUSS_EN
    if (m == 2) return s / 16;
`endif
    return s / 9;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Random 50% stall on the second instance's output when enabled.
  always @(posedge clk) begin
    #1;
    rdy1 = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pops the scoreboard on every output transfer and checks stall stability.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      mon_rdy = (d == 0) ? rdy0 : rdy1;
      if (!reset && hold_v[d]) begin
        chk($sformatf("dut%0d_stall_hold", d),
            int'({out_valid[d], out_sof[d], out_eol[d], out_data[d]}), int'(hold_w[d]));
      end
      if (!reset && out_valid[d] && mon_rdy) begin
        if ((d == 0 ? q0.size() : q1.size()) == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL dut%0d_unexpected_out: got data %0d, expected no output", d, out_data[d]);
        end else begin
          if (d == 0) mon_e = q0.pop_front();
          else        mon_e = q1.pop_front();
          chk($sformatf("dut%0d_data", d), int'(out_data[d]), int'(mon_e.dat));
          chk($sformatf("dut%0d_sof", d), int'(out_sof[d]), int'(mon_e.sof));
          chk($sformatf("dut%0d_eol", d), int'(out_eol[d]), int'(mon_e.eol));
        end
        if (d == 0) cap0.push_back(int'(out_data[0]));
      end
      hold_v[d] = !reset && out_valid[d] && !mon_rdy;
      hold_w[d] = {1'b1, out_sof[d], out_eol[d], out_data[d]};
    end
  end

  task automatic push_exp(input int d, input int kind, input int m, input int n);
    exp_t e;
    int r;
    int c;
    for (int i = 0; i < n; i++) begin
      r     = i / img_w(d);
      c     = i % img_w(d);
      e.dat = 8'(model(kind, img_w(d), img_h(d), m, r, c));
      e.sof = (i == 0);
      e.eol = (c == img_w(d) - 1);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic send_pix(input int d, input int v);
    int t;
    t           = 0;
    in_valid[d] = 1'b1;
    in_data[d]  = 8'(v);
    forever begin
      @(negedge clk);
      if (in_ready[d]) break;
      t++;
      if (t > 300) begin
        n_vec++;
        n_err++;
        $display("FAIL dut%0d_in_ready_timeout: got in_ready=0 for %0d cycles, expected 1", d, t);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic run_frame(input int d, input int kind, input int m, input int n_send, input int n_exp);
    md[d] = 2'(m);
    push_exp(d, kind, m, n_exp);
    for (int i = 0; i < n_send; i++) begin
      send_pix(d, pat(kind, img_w(d), i / img_w(d), i % img_w(d)));
    end
  endtask

  task automatic wait_drain(input int d);
    int t;
    t = 0;
    while ((d == 0 ? q0.size() : q1.size()) != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) begin
      n_vec++;
      n_err++;
      $display("FAIL dut%0d_drain_timeout: got %0d outputs missing, expected 0", d,
               (d == 0 ? q0.size() : q1.size()));
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input int d);
    chk($sformatf("dut%0d_rst_out_valid", d), int'(out_valid[d]), 0);
    chk($sformatf("dut%0d_rst_out_data", d), int'(out_data[d]), 0);
    chk($sformatf("dut%0d_rst_out_sof", d), int'(out_sof[d]), 0);
    chk($sformatf("dut%0d_rst_out_eol", d), int'(out_eol[d]), 0);
    chk($sformatf("dut%0d_rst_in_ready", d), int'(in_ready[d]), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion, expected $finish before the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    in_valid = '0;
    in_data  = '0;
    md       = '0;
    rdy0     = 1'b1;
    stall_en = 1'b0;
    hold_v   = '{default: 1'b0};
    hold_w   = '{default: '0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outs(0);
    chk_reset_outs(1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Flat frame: every output 100, sof on first, eol every 4th.
    run_frame(0, K_C100, 0, 16, 16);
    wait_drain(0);

    // Ramp box mean, with hand-derived corner/centre values.
    cap0.delete();
    run_frame(0, K_RAMP, 0, 16, 16);
    wait_drain(0);
    chk("ramp_box_(0,0)", (cap0.size() > 0) ? cap0[0] : -1, 1);
    chk("ramp_box_(1,1)", (cap0.size() > 5) ? cap0[5] : -1, 5);
    chk("ramp_box_(3,3)", (cap0.size() > 15) ? cap0[15] : -1, 13);

    // Bypass: outputs are the inputs 0..15.
    run_frame(0, K_RAMP, 1, 16, 16);
    wait_drain(0);

    // Mode 10 (box unless the gaussian build is selected) and mode 11 (box).
    run_frame(0, K_RAMP, 2, 16, 16);
    wait_drain(0);
`ifdef GAUSS_EN
    run_frame(0, K_C255, 2, 16, 16);
    wait_drain(0);
`endif
    run_frame(0, K_RAMP, 3, 16, 16);
    wait_drain(0);

    // Abort after 7 pixels: (0,0) and (0,1) already emerge, then reset.
    run_frame(0, K_RAMP, 0, 7, 2);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outs(0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_frame(0, K_C100, 0, 16, 16);
    wait_drain(0);

    // 8x5 frame: random stalls, then no stalls, then bypass under stalls.
    stall_en = 1'b1;
    run_frame(1, K_HASH, 0, 40, 40);
    wait_drain(1);
    stall_en = 1'b0;
    run_frame(1, K_HASH, 0, 40, 40);
    wait_drain(1);
    stall_en = 1'b1;
    run_frame(1, K_HASH, 1, 40, 40);
    wait_drain(1);
    stall_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
